// File: rtl/ws2812_rx_if.sv
// ----------------------------------------------------------------------------
// ws2812_rx_if
// Bundles the serial LED line and the decoded pixel/frame stream of the
// WS2812 receiver.
//   master : the decoder; samples leds_line, drives the decoded outputs
//   slave  : the line driver / consumer; drives leds_line, reads the outputs
// Signals:
//   leds_line      serial GRB line, idle low
//   pixel_grb      last completed pixel, G[23:16] R[15:8] B[7:0]
//   pixel_valid    one-cycle strobe, pixel_grb/pixel_index are new
//   pixel_index    0-based position of that pixel in the frame
//   frame_end      one-cycle strobe on a latch gap
//   pixel_count    pixels in the frame just ended (saturating)
//   frame_overflow frame just ended carried more pixels than the chain holds
//   line_error     sticky error flag
// ----------------------------------------------------------------------------
interface ws2812_rx_if #(
    parameter int PW = 7
);
    logic          leds_line;
    logic [23:0]   pixel_grb;
    logic          pixel_valid;
    logic [PW-1:0] pixel_index;
    logic          frame_end;
    logic [PW-1:0] pixel_count;
    logic          frame_overflow;
    logic          line_error;

    modport master (
        input  leds_line,
        output pixel_grb, pixel_valid, pixel_index, frame_end,
        output pixel_count, frame_overflow, line_error
    );

    modport slave (
        output leds_line,
        input  pixel_grb, pixel_valid, pixel_index, frame_end,
        input  pixel_count, frame_overflow, line_error
    );
endinterface

// File: rtl/ws2812_rx.sv
// ----------------------------------------------------------------------------
// ws2812_rx
// Decodes a WS2812 single-wire GRB line back into 24-bit pixel words by
// measuring high-pulse widths; low gaps of RESET_LOW_CLK clocks end a frame.
// Ports:
//   clk          rising-edge clock for all logic
//   force_reset  asynchronous active-high reset
//   bus          ws2812_rx_if.master (leds_line in, decoded stream out)
// ----------------------------------------------------------------------------
module ws2812_rx #(
    parameter int MIN_HIGH_CLK      = 2,
    parameter int BIT_THRESHOLD_CLK = 7,
    parameter int MAX_HIGH_CLK      = 40,
    parameter int RESET_LOW_CLK     = 600,
    parameter int MAX_POS           = 109
) (
    input  logic        clk,
    input  logic        force_reset,
    ws2812_rx_if.master bus
);
    localparam int PW = $clog2(MAX_POS + 1);
    localparam int LW = $clog2(RESET_LOW_CLK + 1);
    localparam int HW = $clog2(MAX_HIGH_CLK + 1);

    localparam logic [LW-1:0] LOW_SAT   = LW'(RESET_LOW_CLK);
    localparam logic [LW-1:0] LOW_LAST  = LW'(RESET_LOW_CLK - 1);
    localparam logic [HW-1:0] HIGH_LAST = HW'(MAX_HIGH_CLK - 1);
    localparam logic [HW-1:0] HIGH_MIN  = HW'(MIN_HIGH_CLK);
    localparam logic [HW-1:0] HIGH_ONE  = HW'(BIT_THRESHOLD_CLK);
    localparam logic [PW-1:0] POS_MAX   = PW'(MAX_POS);

    typedef enum logic [1:0] {
        ST_SYNC      = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_LOW       = 2'd3
    } state_t;

    logic          r_sync1;
    logic          r_din;
    state_t        r_state;
    logic [LW-1:0] r_low_cnt;
    logic [HW-1:0] r_high_cnt;
    logic [23:0]   r_shift;
    logic [4:0]    r_bit_cnt;
    logic [PW-1:0] r_index;
    logic          r_ovf;
    logic [23:0]   r_pixel_grb;
    logic          r_pixel_valid;
    logic [PW-1:0] r_pixel_index;
    logic          r_frame_end;
    logic [PW-1:0] r_pixel_count;
    logic          r_frame_overflow;
    logic          r_line_error;

    state_t        w_state_nxt;
    logic          w_low_clr;
    logic          w_low_one;
    logic          w_low_inc;
    logic          w_high_one;
    logic          w_high_inc;
    logic          w_bit_shift;
    logic          w_bit_val;
    logic          w_frame_end;
    logic          w_abort;
    logic [23:0]   w_shift_nxt;

    assign w_shift_nxt = {r_shift[22:0], w_bit_val};

    // Two-flop synchronizer for the line and FSM state register.
    always_ff @(posedge clk or posedge force_reset) begin
        if (force_reset) begin
            r_sync1 <= 1'b0;
            r_din   <= 1'b0;
            r_state <= ST_SYNC;
        end else begin
            r_sync1 <= bus.leds_line;
            r_din   <= r_sync1;
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_low_clr   = 1'b0;
        w_low_one   = 1'b0;
        w_low_inc   = 1'b0;
        w_high_one  = 1'b0;
        w_high_inc  = 1'b0;
        w_bit_shift = 1'b0;
        w_bit_val   = 1'b0;
        w_frame_end = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_SYNC: begin
                // Any high restarts the search for an unbroken low gap.
                if (r_din) begin
                    w_low_clr = 1'b1;
                end else if (r_low_cnt == LOW_LAST) begin
                    w_low_inc   = 1'b1;
                    w_state_nxt = ST_WAIT_HIGH;
                end else begin
                    w_low_inc = 1'b1;
                end
            end
            ST_WAIT_HIGH, ST_LOW: begin
                // The rising cycle is itself the first high clock.
                if (r_din) begin
                    w_high_one  = 1'b1;
                    w_state_nxt = ST_HIGH;
                end else if (r_low_cnt == LOW_LAST) begin
                    w_low_inc   = 1'b1;
                    w_frame_end = 1'b1;
                    w_state_nxt = ST_WAIT_HIGH;
                end else begin
                    w_low_inc = 1'b1;
                end
            end
            ST_HIGH: begin
                if (r_din) begin
                    if (r_high_cnt == HIGH_LAST) begin
                        w_abort     = 1'b1;
                        w_low_clr   = 1'b1;
                        w_state_nxt = ST_SYNC;
                    end else begin
                        w_high_inc = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_LOW;
                    // A glitch leaves the low counter untouched so the gap
                    // measurement carries on across it.
                    if (r_high_cnt >= HIGH_MIN) begin
                        w_bit_shift = 1'b1;
                        w_bit_val   = (r_high_cnt >= HIGH_ONE);
                        w_low_one   = 1'b1;
                    end else begin
                        w_bit_shift = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_SYNC;
            end
        endcase
    end

    // Low-time and high-time pulse counters.
    always_ff @(posedge clk or posedge force_reset) begin
        if (force_reset) begin
            r_low_cnt  <= {LW{1'b0}};
            r_high_cnt <= {HW{1'b0}};
        end else begin
            if (w_low_clr) begin
                r_low_cnt <= {LW{1'b0}};
            end else if (w_low_one) begin
                r_low_cnt <= {{(LW-1){1'b0}}, 1'b1};
            end else if (w_low_inc && (r_low_cnt != LOW_SAT)) begin
                r_low_cnt <= r_low_cnt + {{(LW-1){1'b0}}, 1'b1};
            end
            if (w_high_one) begin
                r_high_cnt <= {{(HW-1){1'b0}}, 1'b1};
            end else if (w_high_inc) begin
                r_high_cnt <= r_high_cnt + {{(HW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Bit assembly, pixel/frame bookkeeping and registered outputs.
    always_ff @(posedge clk or posedge force_reset) begin
        if (force_reset) begin
            r_shift          <= 24'd0;
            r_bit_cnt        <= 5'd0;
            r_index          <= {PW{1'b0}};
            r_ovf            <= 1'b0;
            r_pixel_grb      <= 24'd0;
            r_pixel_valid    <= 1'b0;
            r_pixel_index    <= {PW{1'b0}};
            r_frame_end      <= 1'b0;
            r_pixel_count    <= {PW{1'b0}};
            r_frame_overflow <= 1'b0;
            r_line_error     <= 1'b0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_frame_end   <= 1'b0;
            if (w_abort) begin
                // Over-long high: drop the whole frame in progress.
                r_bit_cnt    <= 5'd0;
                r_index      <= {PW{1'b0}};
                r_ovf        <= 1'b0;
                r_line_error <= 1'b1;
            end else if (w_frame_end) begin
                r_frame_end      <= 1'b1;
                r_pixel_count    <= r_index;
                r_frame_overflow <= r_ovf;
                r_index          <= {PW{1'b0}};
                r_ovf            <= 1'b0;
                r_bit_cnt        <= 5'd0;
                if (r_bit_cnt != 5'd0) begin
                    r_line_error <= 1'b1;
                end
            end else if (w_bit_shift) begin
                r_shift <= w_shift_nxt;
                if (r_bit_cnt == 5'd23) begin
                    r_bit_cnt <= 5'd0;
                    // r_index saturates at MAX_POS, so it doubles as the count.
                    if (r_index < POS_MAX) begin
                        r_pixel_grb   <= w_shift_nxt;
                        r_pixel_valid <= 1'b1;
                        r_pixel_index <= r_index;
                        r_index       <= r_index + {{(PW-1){1'b0}}, 1'b1};
                    end else begin
                        r_ovf <= 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
            end
        end
    end

    assign bus.pixel_grb      = r_pixel_grb;
    assign bus.pixel_valid    = r_pixel_valid;
    assign bus.pixel_index    = r_pixel_index;
    assign bus.frame_end      = r_frame_end;
    assign bus.pixel_count    = r_pixel_count;
    assign bus.frame_overflow = r_frame_overflow;
    assign bus.line_error     = r_line_error;
endmodule

// File: tb/tb_ws2812_rx.sv
// ----------------------------------------------------------------------------
// tb_ws2812_rx
// Directed stimulus for ws2812_rx with a queue-based scoreboard: expected
// pixels and frame ends are queued as traffic is issued, and a monitor
// process compares them whenever the receiver strobes an output.
// ----------------------------------------------------------------------------
module tb_ws2812_rx;
    localparam int PW = 7;

    typedef struct packed {
        logic [23:0]   grb;
        logic [PW-1:0] idx;
    } pix_t;

    typedef struct packed {
        logic [PW-1:0] cnt;
        logic          ovf;
        logic          err;
    } frm_t;

    logic clk;
    logic force_reset;
    int   total;
    int   bad;
    pix_t pix_q[$];
    frm_t frm_q[$];

    ws2812_rx_if #(.PW(PW)) bus ();

    ws2812_rx dut (
        .clk         (clk),
        .force_reset (force_reset),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        bus.leds_line = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int h, input int l);
        drive(1'b1, h);
        drive(1'b0, l);
    endtask

    task automatic send_bit(input logic b);
        if (b) pulse(10, 5);
        else   pulse(5, 10);
    endtask

    task automatic send_pixel(input logic [23:0] p);
        for (int i = 23; i >= 0; i--) send_bit(p[i]);
    endtask

    task automatic exp_pix(input logic [23:0] grb, input int idx);
        pix_t e;
        e.grb = grb;
        e.idx = PW'(idx);
        pix_q.push_back(e);
    endtask

    task automatic exp_frm(input int cnt, input logic ovf, input logic err);
        frm_t e;
        e.cnt = PW'(cnt);
        e.ovf = ovf;
        e.err = err;
        frm_q.push_back(e);
    endtask

    task automatic check_reset_outputs();
        check("rst_pixel_grb",   32'(bus.pixel_grb),      32'd0);
        check("rst_pixel_valid", 32'(bus.pixel_valid),    32'd0);
        check("rst_pixel_index", 32'(bus.pixel_index),    32'd0);
        check("rst_frame_end",   32'(bus.frame_end),      32'd0);
        check("rst_pixel_count", 32'(bus.pixel_count),    32'd0);
        check("rst_overflow",    32'(bus.frame_overflow), 32'd0);
        check("rst_line_error",  32'(bus.line_error),     32'd0);
    endtask

    task automatic monitor();
        pix_t p;
        frm_t f;
        forever begin
            @(negedge clk);
            if (bus.pixel_valid || bus.frame_end) begin
                check("valid_end_exclusive", 32'(bus.pixel_valid & bus.frame_end), 32'd0);
            end
            if (bus.pixel_valid) begin
                if (pix_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pixel: got grb=0x%06h idx=%0d want none",
                             bus.pixel_grb, bus.pixel_index);
                end else begin
                    p = pix_q.pop_front();
                    check("pixel_grb",   32'(bus.pixel_grb),   32'(p.grb));
                    check("pixel_index", 32'(bus.pixel_index), 32'(p.idx));
                end
            end
            if (bus.frame_end) begin
                if (frm_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame_end: got count=%0d want none", bus.pixel_count);
                end else begin
                    f = frm_q.pop_front();
                    check("pixel_count",    32'(bus.pixel_count),    32'(f.cnt));
                    check("frame_overflow", 32'(bus.frame_overflow), 32'(f.ovf));
                    check("line_error",     32'(bus.line_error),     32'(f.err));
                end
            end
        end
    endtask

    initial begin
        logic [23:0] v;
        total = 0;
        bad   = 0;
        bus.leds_line = 1'b0;
        force_reset   = 1'b1;
        fork
            monitor();
        join_none
        repeat (4) @(negedge clk);
        check_reset_outputs();
        force_reset = 1'b0;

        // Initial gap only synchronises: no frame_end expected.
        drive(1'b0, 610);

        // Single pixel frame.
        exp_pix(24'h00FF00, 0);
        send_pixel(24'h00FF00);
        exp_frm(1, 1'b0, 1'b0);
        drive(1'b0, 610);

        // 110 pixels into a 109-pixel chain.
        for (int n = 0; n < 110; n++) begin
            if (n < 109) exp_pix(24'h000001 + 24'(n), n);
            send_pixel(24'h000001 + 24'(n));
        end
        exp_frm(109, 1'b1, 1'b0);
        drive(1'b0, 610);
        exp_pix(24'h123456, 0);
        send_pixel(24'h123456);
        exp_frm(1, 1'b0, 1'b0);
        drive(1'b0, 610);

        // Glitch plus width boundaries: 6->0, 7->1, 2->0, 39->1.
        v = {4'hA, 4'b0101, 16'hC5A5};
        exp_pix(v, 0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        pulse(1, 6);
        pulse(6, 9);
        pulse(7, 8);
        pulse(2, 13);
        pulse(39, 5);
        for (int i = 15; i >= 0; i--) send_bit(v[i]);
        exp_frm(1, 1'b0, 1'b0);
        drive(1'b0, 610);

        // Partial pixel (12 bits) before a gap.
        for (int i = 0; i < 12; i++) send_bit(i[0]);
        exp_frm(0, 1'b0, 1'b1);
        drive(1'b0, 610);
        exp_pix(24'hABCDEF, 0);
        send_pixel(24'hABCDEF);
        exp_frm(1, 1'b0, 1'b1);
        drive(1'b0, 610);

        // Line stuck high mid-frame.
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        drive(1'b1, 45);
        drive(1'b0, 5);
        check("stuck_high_error", 32'(bus.line_error), 32'd1);
        send_pixel(24'hFFFFFF);
        send_pixel(24'h13579B);
        drive(1'b0, 610);
        exp_pix(24'h5A5A5A, 0);
        send_pixel(24'h5A5A5A);
        exp_frm(1, 1'b0, 1'b1);
        drive(1'b0, 610);

        // Reset mid-pixel, then traffic with no leading gap.
        for (int i = 0; i < 10; i++) send_bit(i[1]);
        force_reset = 1'b1;
        drive(1'b0, 3);
        check_reset_outputs();
        force_reset = 1'b0;
        send_pixel(24'h112233);
        send_pixel(24'h445566);
        drive(1'b0, 610);
        exp_pix(24'h0F0F0F, 0);
        send_pixel(24'h0F0F0F);
        exp_frm(1, 1'b0, 1'b0);
        drive(1'b0, 620);

        check("pix_q_drained", 32'(pix_q.size()), 32'd0);
        check("frm_q_drained", 32'(frm_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
